// File: rtl/mdu_sequencer_if.sv
// Handshake/bus bundle between the E-stage control and the MDU.
// With MDU_FLUSH_EN defined the bundle carries an extra flush line.
interface mdu_sequencer_if;
    logic        start;
    logic [3:0]  mdu_type;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_use_mdu;
`ifdef MDU_FLUSH_EN
    logic        flush;
`endif
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

`ifdef MDU_FLUSH_EN
    modport master (
        output start, mdu_type, rs_val, rt_val, d_use_mdu, flush,
        input  busy, stall, hi, lo, rd_data
    );
    modport slave (
        input  start, mdu_type, rs_val, rt_val, d_use_mdu, flush,
        output busy, stall, hi, lo, rd_data
    );
`else
    modport master (
        output start, mdu_type, rs_val, rt_val, d_use_mdu,
        input  busy, stall, hi, lo, rd_data
    );
    modport slave (
        input  start, mdu_type, rs_val, rt_val, d_use_mdu,
        output busy, stall, hi, lo, rd_data
    );
`endif
endinterface

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer with committed HI/LO registers.
// The result is computed at the start edge and held in pending registers;
// it becomes architecturally visible only when the busy countdown expires.
// Optional feature: define MDU_FLUSH_EN to add a flush line that aborts
// an in-flight operation without touching HI/LO.
module mdu_sequencer #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic            clk,
    input logic            reset,
    mdu_sequencer_if.slave bus
);
    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic [31:0]     pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

    logic        is_md, is_div, start_md, accept_md, can_start, flush_req;
    logic [63:0] prod_s, prod_u;
    logic [31:0] div_rt, quo_s, rem_s, quo_u, rem_u, res_hi, res_lo;
    logic [CntW-1:0] load_cnt;
    logic        div_ovf;

    // Operation decode and result datapath
    always_comb begin
        is_md     = (bus.mdu_type >= 4'd1) && (bus.mdu_type <= 4'd4);
        is_div    = (bus.mdu_type == 4'd3) || (bus.mdu_type == 4'd4);
        start_md  = bus.start && is_md;
        // Divide-by-zero is swallowed as a NOP, so it never enters BUSY.
        accept_md = start_md && !(is_div && (bus.rt_val == 32'd0));
        load_cnt  = is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);

        prod_s = $signed({{32{bus.rs_val[31]}}, bus.rs_val}) *
                 $signed({{32{bus.rt_val[31]}}, bus.rt_val});
        prod_u = {32'd0, bus.rs_val} * {32'd0, bus.rt_val};

        // Keep the divider away from a zero divisor; the result is unused then.
        div_rt  = (bus.rt_val == 32'd0) ? 32'd1 : bus.rt_val;
        // INT_MIN / -1 overflows; pin the architectural answer explicitly.
        div_ovf = (bus.rs_val == 32'h8000_0000) && (bus.rt_val == 32'hFFFF_FFFF);
        quo_s   = div_ovf ? 32'h8000_0000 : 32'($signed(bus.rs_val) / $signed(div_rt));
        rem_s   = div_ovf ? 32'd0         : 32'($signed(bus.rs_val) % $signed(div_rt));
        quo_u   = bus.rs_val / div_rt;
        rem_u   = bus.rs_val % div_rt;

        res_hi = 32'd0;
        res_lo = 32'd0;
        case (bus.mdu_type)
            4'd1:    begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
            4'd2:    begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
            4'd3:    begin res_hi = rem_s;         res_lo = quo_s;        end
            4'd4:    begin res_hi = rem_u;         res_lo = quo_u;        end
            default: ;
        endcase
    end

    // Next-state: countdown, commit, move-to, and start acceptance
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
`ifdef MDU_FLUSH_EN
        flush_req = bus.flush;
`else
        flush_req = 1'b0;
`endif
        // The completion cycle may accept a new op so busy shows no gap.
        can_start = (state_q == StIdle) || (cnt_q == CntW'(1));

        case (state_q)
            StIdle: begin
                if (bus.start && (bus.mdu_type == 4'd7)) hi_d = bus.rs_val;
                if (bus.start && (bus.mdu_type == 4'd8)) lo_d = bus.rs_val;
            end
            StBusy: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (can_start && accept_md) begin
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
            cnt_d     = load_cnt;
            state_d   = StBusy;
        end

        // Flush wins over everything, including a same-cycle start or commit.
        if (flush_req) begin
            state_d   = StIdle;
            cnt_d     = '0;
            pend_hi_d = 32'd0;
            pend_lo_d = 32'd0;
            hi_d      = hi_q;
            lo_d      = lo_q;
        end
    end

    // State and register file update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    // Outputs: status, hazard stall and move-from read port
    always_comb begin
        bus.busy    = (state_q == StBusy);
        bus.stall   = bus.d_use_mdu && (start_md || (state_q == StBusy));
        bus.hi      = hi_q;
        bus.lo      = lo_q;
        bus.rd_data = (bus.mdu_type == 4'd5) ? hi_q :
                      (bus.mdu_type == 4'd6) ? lo_q : 32'd0;
    end
endmodule
